// File: rtl/mux_arb_n_way.sv
// Registered N-way mux: arbitrates between WAYS valid/ready producers (round-robin or
// fixed priority) and holds the winning word in a single output register.
module mux_arb_n_way #(
    parameter int WAYS  = 4,
    parameter int WIDTH = 16,
    parameter int SEL_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data [WAYS],
    input  logic [WAYS-1:0]  in_valid,
    output logic [WAYS-1:0]  in_ready,
    input  logic             mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_sel
);

    // Handshake: a word moves across any valid/ready pair on the rising edge where both
    // are high. in_ready is one-hot (or zero) and never depends on in_data.
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] cand_idx;
    int               cand;

    // Search starts at ptr (round-robin) or 0 (fixed priority) and wraps at WAYS-1.
    always_comb begin
        load        = !out_valid_q || out_ready;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        cand        = 0;
        in_ready    = '0;
        for (int k = 0; k < WAYS; k++) begin
            cand = (mode ? 0 : int'(ptr_q)) + k;
            if (cand >= WAYS) begin
                cand = cand - WAYS;
            end
            cand_idx = SEL_W'(cand);
            if (!grant_found && in_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        if (load && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load && grant_found) begin
            out_data_d  = in_data[grant_idx];
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (!mode) begin
                ptr_d = (grant_idx == SEL_W'(WAYS - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule
